regfile_mp: RTL and testbench

- Parametrised multi-port register file for the core's decode/writeback boundary.
- Provides NUM_RD synchronous read ports and two write ports: port A for ALU results, port B for load results.
- Holds a dedicated PC slot, loaded from the fetch stage each cycle, and a per-register busy scoreboard for outstanding loads.
- Sits between decode (read addresses), execute/memory (write-back) and fetch (PC).

---
 rtl/regfile_mp.sv | 90 +++++++++
 tb/tb_regfile_mp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, ALU/load write ports, PC slot, load scoreboard.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on the read ports (default: read-first).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 3,
  parameter int SP_IDX   = 13,
  parameter int PC_IDX   = 15,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wa_en,
  input  logic [ADDR_W-1:0]        i_wa_addr,
  input  logic [DATA_W-1:0]        i_wa_data,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_busy_set,
  input  logic [ADDR_W-1:0]        i_busy_addr,
  input  logic [DATA_W-1:0]        i_pc,
  output logic [DATA_W-1:0]        o_pc,
  output logic                     o_pc_wr,
  output logic [NUM_REGS-1:0]      o_busy
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_pc_wr;
  logic                w_wa_pc;
  logic                w_wb_pc;

  assign w_wa_pc = i_wa_en && (i_wa_addr == PC_A);
  assign w_wb_pc = i_wb_en && (i_wb_addr == PC_A);

  // Later non-blocking assignments win: PC default < port B < port A, busy clear < busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= (r == SP_IDX) ? SP_RESET : '0;
      end
      r_busy  <= '0;
      r_pc_wr <= 1'b0;
    end else begin
      r_regs[PC_IDX] <= i_pc;
      if (i_wb_en) r_regs[i_wb_addr] <= i_wb_data;
      if (i_wa_en) r_regs[i_wa_addr] <= i_wa_data;
      if (i_wb_en) r_busy[i_wb_addr] <= 1'b0;
      if (i_busy_set && (i_busy_addr != PC_A)) r_busy[i_busy_addr] <= 1'b1;
      r_pc_wr <= w_wa_pc || w_wb_pc;
    end
  end

  assign o_pc    = r_regs[PC_IDX];
  assign o_pc_wr = r_pc_wr;
  assign o_busy  = r_busy;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    assign w_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // Forward what the register will hold after this edge.
    always_comb begin
      w_data = r_regs[w_addr];
      if (w_addr == PC_A) w_data = i_pc;
      if (i_wb_en && (i_wb_addr == w_addr)) w_data = i_wb_data;
      if (i_wa_en && (i_wa_addr == w_addr)) w_data = i_wa_data;
    end
`else
    assign w_data = r_regs[w_addr];
`endif

    always_ff @(posedge clk) begin
      if (rst) r_data <= '0;
      else     r_data <= w_data;
    end

    assign o_rd_data[gi*DATA_W +: DATA_W] = r_data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; read results are checked through an expectation queue.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NREG = 16;
  localparam int AW = 4;
  localparam int NRD = 3;
  localparam logic [31:0] SPR = 32'h0000_8000;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] i_rd_addr;
  logic [NRD*DW-1:0] o_rd_data;
  logic              i_wa_en, i_wb_en, i_busy_set;
  logic [AW-1:0]     i_wa_addr, i_wb_addr, i_busy_addr;
  logic [DW-1:0]     i_wa_data, i_wb_data, i_pc, o_pc;
  logic              o_pc_wr;
  logic [NREG-1:0]   o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [95:0]  exp;
  } rd_exp_t;
  rd_exp_t sb[$];

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NREG), .NUM_RD(NRD), .SP_RESET(SPR)) dut (
    .clk(clk), .rst(rst),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_wa_en(i_wa_en), .i_wa_addr(i_wa_addr), .i_wa_data(i_wa_data),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_busy_set(i_busy_set), .i_busy_addr(i_busy_addr),
    .i_pc(i_pc), .o_pc(o_pc), .o_pc_wr(o_pc_wr), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected read data for the addresses driven this cycle.
  task automatic rd(input string tag, input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    rd_exp_t e;
    i_rd_addr = {a2, a1, a0};
    e.tag = tag;
    e.exp = {e2, e1, e0};
    sb.push_back(e);
  endtask

  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, o_rd_data, e.exp);
      $display("t=%0t rd %s data=%h busy=%h pc=%h pc_wr=%b", $time, e.tag, o_rd_data, o_busy, o_pc, o_pc_wr);
    end else begin
      $display("t=%0t cyc busy=%h pc=%h pc_wr=%b", $time, o_busy, o_pc, o_pc_wr);
    end
  endtask

  task automatic idle_wr();
    i_wa_en = 1'b0; i_wb_en = 1'b0; i_busy_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_rd_addr = '0; i_pc = 32'h40;
    i_wa_en = 1'b0; i_wa_addr = '0; i_wa_data = '0;
    i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_busy_set = 1'b0; i_busy_addr = '0;
    tick(); tick();
    chk("reset_rd", o_rd_data, 96'h0);
    chk("reset_busy", 96'(o_busy), 96'h0);
    chk("reset_pc", 96'(o_pc), 96'h0);
    chk("reset_pcwr", 96'(o_pc_wr), 96'h0);
    rst = 1'b0;

    // Reads of SP, r0 and PC straight after reset
    rd("rd_sp_r0_pc", 4'd13, 4'd0, 4'd15, SPR, 32'h0, BYP ? 32'h40 : 32'h0);
    tick();
    chk("pc_follow", 96'(o_pc), 96'h40);
    i_pc = 32'h44;
    rd("rd_pc_again", 4'd13, 4'd0, 4'd15, SPR, 32'h0, BYP ? 32'h44 : 32'h40);
    tick();
    chk("pc_follow2", 96'(o_pc), 96'h44);

    // Port A write with same-cycle read, then the following read
    i_wa_en = 1'b1; i_wa_addr = 4'd3; i_wa_data = 32'hDEADBEEF;
    rd("rd_r3_same", 4'd3, 4'd3, 4'd3, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0,
       BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    idle_wr();
    rd("rd_r3_next", 4'd3, 4'd1, 4'd2, 32'hDEADBEEF, 32'h0, 32'h0);
    tick();

    // Same-address A/B write: A wins, B still clears busy
    i_busy_set = 1'b1; i_busy_addr = 4'd5;
    tick();
    chk("busy5_set", 96'(o_busy), 96'h20);
    idle_wr();
    i_wa_en = 1'b1; i_wa_addr = 4'd5; i_wa_data = 32'h11;
    i_wb_en = 1'b1; i_wb_addr = 4'd5; i_wb_data = 32'h22;
    rd("rd_r5_same", 4'd5, 4'd0, 4'd5, BYP ? 32'h11 : 32'h0, 32'h0, BYP ? 32'h11 : 32'h0);
    tick();
    chk("busy5_clr", 96'(o_busy), 96'h0);
    idle_wr();
    rd("rd_r5_next", 4'd5, 4'd5, 4'd5, 32'h11, 32'h11, 32'h11);
    tick();

    // Busy set and B clear on one register: set wins
    i_busy_set = 1'b1; i_busy_addr = 4'd7;
    i_wb_en = 1'b1; i_wb_addr = 4'd7; i_wb_data = 32'h44;
    tick();
    chk("busy7_setwins", 96'(o_busy), 96'h80);
    idle_wr();
    i_wb_en = 1'b1; i_wb_addr = 4'd7; i_wb_data = 32'h55;
    rd("rd_r7_same", 4'd7, 4'd7, 4'd5, BYP ? 32'h55 : 32'h44, BYP ? 32'h55 : 32'h44, 32'h11);
    tick();
    chk("busy7_clr", 96'(o_busy), 96'h0);
    idle_wr();
    rd("rd_r7_next", 4'd7, 4'd3, 4'd5, 32'h55, 32'hDEADBEEF, 32'h11);
    tick();

    // PC overwritten by port A; busy set on PC ignored
    i_pc = 32'h100;
    i_wa_en = 1'b1; i_wa_addr = 4'd15; i_wa_data = 32'h2000;
    i_busy_set = 1'b1; i_busy_addr = 4'd15;
    tick();
    chk("pc_wrA", 96'(o_pc), 96'h2000);
    chk("pcwr_pulse", 96'(o_pc_wr), 96'h1);
    chk("busy_pc_ign", 96'(o_busy), 96'h0);
    idle_wr();
    tick();
    chk("pc_after", 96'(o_pc), 96'h100);
    chk("pcwr_low", 96'(o_pc_wr), 96'h0);

    // Port B write to PC also pulses o_pc_wr
    i_wb_en = 1'b1; i_wb_addr = 4'd15; i_wb_data = 32'h3000;
    tick();
    chk("pc_wrB", 96'(o_pc), 96'h3000);
    chk("pcwrB_pulse", 96'(o_pc_wr), 96'h1);
    idle_wr();
    tick();

    // Mid-operation reset discards everything including that cycle's writes
    i_wa_en = 1'b1; i_wa_addr = 4'd2; i_wa_data = 32'h9;
    i_busy_set = 1'b1; i_busy_addr = 4'd4;
    tick();
    chk("busy4_set", 96'(o_busy), 96'h10);
    idle_wr();
    rd("rd_r2", 4'd2, 4'd13, 4'd4, 32'h9, SPR, 32'h0);
    tick();
    rst = 1'b1;
    i_wa_en = 1'b1; i_wa_addr = 4'd2; i_wa_data = 32'h77;
    i_busy_set = 1'b1; i_busy_addr = 4'd4;
    tick();
    rst = 1'b0;
    idle_wr();
    chk("rst2_rd", o_rd_data, 96'h0);
    chk("rst2_busy", 96'(o_busy), 96'h0);
    chk("rst2_pc", 96'(o_pc), 96'h0);
    chk("rst2_pcwr", 96'(o_pc_wr), 96'h0);
    rd("rd_after_rst", 4'd2, 4'd13, 4'd15, 32'h0, SPR, BYP ? 32'h100 : 32'h0);
    tick();
    chk("sb_empty", 96'(sb.size()), 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
